mem_wb_stage_register: RTL and testbench

Parametrised MEM/WB pipeline register for the 16-bit core, replacing the fixed-width, always-loading MEM/WB latch. Adds a valid bit, stall (hold) and flush (bubble insert) control, an asynchronous reset, a registered-source writeback mux, forwarding-match outputs for the hazard unit, and a saturating bubble counter for performance debug. Sits between the memory stage and the register-file write port.

---
 rtl/mem_wb_stage_register.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage_register.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_register.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_register
// MEM/WB pipeline register for the 16-bit core. It holds the memory-stage
// result for one cycle. It has a valid bit, stall (hold) and flush (bubble
// insert) control, and a writeback mux that works from registered fields
// only. It also gives forwarding-match flags for the hazard unit and keeps a
// saturating bubble counter for performance debug.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold all state / replace capture with a bubble
//   *_in                  MEM-stage payload (valid, select, RAM data, ALU
//                         result, destination register, reg_write)
//   src_a_addr/src_b_addr decode-stage sources for the forwarding compare
//   *_out                 registered payload; reg_write_out is gated by valid
//   wb_data_out           mem_to_reg_out ? ram_read_data_out : alu_result_out
//   fwd_a_hit/fwd_b_hit   writeback destination matches src_a/src_b
//   bubble_count          saturating count of bubble captures
// ---------------------------------------------------------------------------
module mem_wb_stage_register #(
    parameter int unsigned DATA_W             = 16,
    parameter int unsigned REG_ADDR_W         = 3,
    parameter int unsigned CNT_W              = 16,
    parameter bit          ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  mem_to_reg_in,
    input  logic [DATA_W-1:0]     ram_read_data_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [REG_ADDR_W-1:0] reg_dst_result_in,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] src_a_addr,
    input  logic [REG_ADDR_W-1:0] src_b_addr,
    output logic                  valid_out,
    output logic                  mem_to_reg_out,
    output logic [DATA_W-1:0]     ram_read_data_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [REG_ADDR_W-1:0] reg_dst_result_out,
    output logic                  reg_write_out,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [CNT_W-1:0]      bubble_count
);

    logic                  valid_r;
    logic                  mem_to_reg_r;
    logic                  reg_write_r;
    logic [DATA_W-1:0]     ram_data_r;
    logic [DATA_W-1:0]     alu_result_r;
    logic [REG_ADDR_W-1:0] reg_dst_r;
    logic [CNT_W-1:0]      bubble_count_r;

    logic                  bubble_event_s;
    logic                  count_sat_s;
    logic                  reg_write_gated_s;
    logic                  zero_dst_block_s;
    logic [DATA_W-1:0]     wb_data_s;
    logic                  fwd_a_hit_s;
    logic                  fwd_b_hit_s;

    // A bubble is any flush, or a load that captures an invalid slot.
    always_comb begin
        bubble_event_s = 1'b0;
        if (flush) begin
            bubble_event_s = 1'b1;
        end else if (!stall) begin
            bubble_event_s = ~valid_in;
        end else begin
            bubble_event_s = 1'b0;
        end
    end

    assign count_sat_s = (bubble_count_r == {CNT_W{1'b1}});

    // Payload registers: flush beats stall, stall beats load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r      <= 1'b0;
            mem_to_reg_r <= 1'b0;
            reg_write_r  <= 1'b0;
            ram_data_r   <= {DATA_W{1'b0}};
            alu_result_r <= {DATA_W{1'b0}};
            reg_dst_r    <= {REG_ADDR_W{1'b0}};
        end else if (flush) begin
            valid_r      <= 1'b0;
            mem_to_reg_r <= 1'b0;
            reg_write_r  <= 1'b0;
            ram_data_r   <= {DATA_W{1'b0}};
            alu_result_r <= {DATA_W{1'b0}};
            reg_dst_r    <= {REG_ADDR_W{1'b0}};
        end else if (stall) begin
            valid_r      <= valid_r;
            mem_to_reg_r <= mem_to_reg_r;
            reg_write_r  <= reg_write_r;
            ram_data_r   <= ram_data_r;
            alu_result_r <= alu_result_r;
            reg_dst_r    <= reg_dst_r;
        end else begin
            // Data fields load even when valid_in is low; valid gates the write.
            valid_r      <= valid_in;
            mem_to_reg_r <= mem_to_reg_in;
            reg_write_r  <= reg_write_in;
            ram_data_r   <= ram_read_data_in;
            alu_result_r <= alu_result_in;
            reg_dst_r    <= reg_dst_result_in;
        end
    end

    // Bubble counter: counts bubble captures and saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count_r <= {CNT_W{1'b0}};
        end else if (bubble_event_s && !count_sat_s) begin
            bubble_count_r <= bubble_count_r + CNT_W'(1);
        end else begin
            bubble_count_r <= bubble_count_r;
        end
    end

    assign reg_write_gated_s = reg_write_r & valid_r;

    // Writeback mux and forwarding compare, driven only from registered fields
    // (the source addresses belong to the decode stage).
    always_comb begin
        wb_data_s        = alu_result_r;
        zero_dst_block_s = 1'b0;
        if (mem_to_reg_r) begin
            wb_data_s = ram_data_r;
        end else begin
            wb_data_s = alu_result_r;
        end
        if (ZERO_REG_HARDWIRED) begin
            zero_dst_block_s = (reg_dst_r == {REG_ADDR_W{1'b0}});
        end else begin
            zero_dst_block_s = 1'b0;
        end
        fwd_a_hit_s = reg_write_gated_s & (reg_dst_r == src_a_addr) & ~zero_dst_block_s;
        fwd_b_hit_s = reg_write_gated_s & (reg_dst_r == src_b_addr) & ~zero_dst_block_s;
    end

    assign valid_out          = valid_r;
    assign mem_to_reg_out     = mem_to_reg_r;
    assign ram_read_data_out  = ram_data_r;
    assign alu_result_out     = alu_result_r;
    assign reg_dst_result_out = reg_dst_r;
    assign reg_write_out      = reg_write_gated_s;
    assign wb_data_out        = wb_data_s;
    assign fwd_a_hit          = fwd_a_hit_s;
    assign fwd_b_hit          = fwd_b_hit_s;
    assign bubble_count       = bubble_count_r;

endmodule

// File: tb/tb_mem_wb_stage_register.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage_register
// Scoreboard bench for mem_wb_stage_register. Three instances share the same
// stimulus: the default configuration, one with ZERO_REG_HARDWIRED=1, and one
// with CNT_W=3. Each drive updates a small reference model and pushes the
// expected next-cycle state. Each scenario task pops that state one cycle
// later and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage_register;

    typedef struct {
        logic [53:0] vec;
        logic [15:0] bub;
        logic [2:0]  bub3;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic        mem_to_reg_in;
    logic [15:0] ram_read_data_in;
    logic [15:0] alu_result_in;
    logic [2:0]  reg_dst_result_in;
    logic        reg_write_in;
    logic [2:0]  src_a_addr;
    logic [2:0]  src_b_addr;

    logic        valid_out, mem_to_reg_out, reg_write_out, fwd_a_hit, fwd_b_hit;
    logic [15:0] ram_read_data_out, alu_result_out, wb_data_out, bubble_count;
    logic [2:0]  reg_dst_result_out;

    logic        z_valid_out, z_mem_to_reg_out, z_reg_write_out, z_fwd_a_hit, z_fwd_b_hit;
    logic [15:0] z_ram_read_data_out, z_alu_result_out, z_wb_data_out, z_bubble_count;
    logic [2:0]  z_reg_dst_result_out;

    logic        c_valid_out, c_mem_to_reg_out, c_reg_write_out, c_fwd_a_hit, c_fwd_b_hit;
    logic [15:0] c_ram_read_data_out, c_alu_result_out, c_wb_data_out;
    logic [2:0]  c_reg_dst_result_out;
    logic [2:0]  c_bubble_count;

    logic [53:0] obs_vec;
    assign obs_vec = {valid_out, reg_write_out, mem_to_reg_out, reg_dst_result_out,
                      ram_read_data_out, alu_result_out, wb_data_out};

    int   tests;
    int   failures;
    exp_t sb[$];
    exp_t e;
    logic [53:0] mdl_vec;
    logic [15:0] mdl_bub;
    logic [2:0]  mdl_bub3;

    mem_wb_stage_register dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .mem_to_reg_in(mem_to_reg_in), .ram_read_data_in(ram_read_data_in),
        .alu_result_in(alu_result_in), .reg_dst_result_in(reg_dst_result_in),
        .reg_write_in(reg_write_in), .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .valid_out(valid_out), .mem_to_reg_out(mem_to_reg_out),
        .ram_read_data_out(ram_read_data_out), .alu_result_out(alu_result_out),
        .reg_dst_result_out(reg_dst_result_out), .reg_write_out(reg_write_out),
        .wb_data_out(wb_data_out), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .bubble_count(bubble_count)
    );

    mem_wb_stage_register #(.ZERO_REG_HARDWIRED(1'b1)) dut_z (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .mem_to_reg_in(mem_to_reg_in), .ram_read_data_in(ram_read_data_in),
        .alu_result_in(alu_result_in), .reg_dst_result_in(reg_dst_result_in),
        .reg_write_in(reg_write_in), .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .valid_out(z_valid_out), .mem_to_reg_out(z_mem_to_reg_out),
        .ram_read_data_out(z_ram_read_data_out), .alu_result_out(z_alu_result_out),
        .reg_dst_result_out(z_reg_dst_result_out), .reg_write_out(z_reg_write_out),
        .wb_data_out(z_wb_data_out), .fwd_a_hit(z_fwd_a_hit), .fwd_b_hit(z_fwd_b_hit),
        .bubble_count(z_bubble_count)
    );

    mem_wb_stage_register #(.CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .mem_to_reg_in(mem_to_reg_in), .ram_read_data_in(ram_read_data_in),
        .alu_result_in(alu_result_in), .reg_dst_result_in(reg_dst_result_in),
        .reg_write_in(reg_write_in), .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .valid_out(c_valid_out), .mem_to_reg_out(c_mem_to_reg_out),
        .ram_read_data_out(c_ram_read_data_out), .alu_result_out(c_alu_result_out),
        .reg_dst_result_out(c_reg_dst_result_out), .reg_write_out(c_reg_write_out),
        .wb_data_out(c_wb_data_out), .fwd_a_hit(c_fwd_a_hit), .fwd_b_hit(c_fwd_b_hit),
        .bubble_count(c_bubble_count)
    );

    // Clock: 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [53:0] mk(input logic v, input logic rw, input logic m2r,
                                       input logic [2:0] dst, input logic [15:0] ram,
                                       input logic [15:0] alu);
        logic [15:0] wb;
        wb = m2r ? ram : alu;
        return {v, rw, m2r, dst, ram, alu, wb};
    endfunction

    task automatic model_reset();
        mdl_vec  = 54'd0;
        mdl_bub  = 16'd0;
        mdl_bub3 = 3'd0;
        sb.delete();
    endtask

    task automatic bump();
        if (mdl_bub != 16'hFFFF) mdl_bub = mdl_bub + 16'd1;
        if (mdl_bub3 != 3'd7) mdl_bub3 = mdl_bub3 + 3'd1;
    endtask

    // Drive one cycle of stimulus and push the model's next-cycle expectation
    task automatic drive(input logic st, input logic fl, input logic v, input logic m2r,
                         input logic [15:0] ram, input logic [15:0] alu,
                         input logic [2:0] dst, input logic rw);
        exp_t x;
        stall = st; flush = fl; valid_in = v; mem_to_reg_in = m2r;
        ram_read_data_in = ram; alu_result_in = alu;
        reg_dst_result_in = dst; reg_write_in = rw;
        if (fl) begin
            mdl_vec = 54'd0;
            bump();
        end else if (!st) begin
            mdl_vec = mk(v, rw & v, m2r, dst, ram, alu);
            if (!v) bump();
        end
        x.vec = mdl_vec; x.bub = mdl_bub; x.bub3 = mdl_bub3;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'd6, 1'b1);
        src_a_addr = 3'd6; src_b_addr = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs_vec !== 54'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", obs_vec);
        end
        tests++;
        if ({bubble_count, fwd_a_hit, fwd_b_hit} !== 18'd0) begin
            failures++; $display("FAIL reset_cnt_fwd: got %h/%b%b expected 0/00", bubble_count, fwd_a_hit, fwd_b_hit);
        end
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'hA5A5, 3'd2, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec) begin
            failures++; $display("FAIL reset_first_load: got %h expected %h", obs_vec, e.vec);
        end
        // Reset between edges must clear without waiting for a clock
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (obs_vec !== 54'd0 || bubble_count !== 16'd0) begin
            failures++; $display("FAIL reset_async: got %h/%h expected 0/0", obs_vec, bubble_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 3'd3, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec || bubble_count !== e.bub) begin
            failures++; $display("FAIL load_alu: got %h/%h expected %h/%h", obs_vec, bubble_count, e.vec, e.bub);
        end
        tests++;
        if ({valid_out, reg_write_out, wb_data_out} !== {1'b1, 1'b1, 16'h1234}) begin
            failures++; $display("FAIL load_alu_wb: got %b%b %h expected 11 1234", valid_out, reg_write_out, wb_data_out);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0001, 3'd6, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec || wb_data_out !== 16'hBEEF) begin
            failures++; $display("FAIL load_ram: got %h wb %h expected %h wb beef", obs_vec, wb_data_out, e.vec);
        end
    endtask

    task automatic test_stall();
        logic [15:0] bub_before;
        bub_before = bubble_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, i[0], ~i[0], 16'h1111 * 16'(i + 1), 16'h2222 * 16'(i + 1), 3'(i), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs_vec !== e.vec || bubble_count !== e.bub || c_bubble_count !== e.bub3) begin
                failures++; $display("FAIL stall_hold[%0d]: got %h/%h expected %h/%h", i, obs_vec, bubble_count, e.vec, e.bub);
            end
        end
        tests++;
        if (bubble_count !== bub_before || wb_data_out !== 16'hBEEF) begin
            failures++; $display("FAIL stall_const: got cnt %h wb %h expected %h beef", bubble_count, wb_data_out, bub_before);
        end
    endtask

    task automatic test_flush_stall();
        logic [15:0] bub_before;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h4444, 16'h7777, 3'd7, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec) begin
            failures++; $display("FAIL flush_pre: got %h expected %h", obs_vec, e.vec);
        end
        bub_before = bubble_count;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h4444, 16'h7777, 3'd7, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec || bubble_count !== e.bub || c_bubble_count !== e.bub3) begin
            failures++; $display("FAIL flush_over_stall: got %h/%h expected %h/%h", obs_vec, bubble_count, e.vec, e.bub);
        end
        tests++;
        if (bubble_count !== bub_before + 16'd1) begin
            failures++; $display("FAIL flush_count: got %h expected %h", bubble_count, bub_before + 16'd1);
        end
    endtask

    task automatic test_fwd();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0055, 3'd5, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec) begin
            failures++; $display("FAIL fwd_load: got %h expected %h", obs_vec, e.vec);
        end
        src_a_addr = 3'd5; src_b_addr = 3'd5; #1;
        tests++;
        if ({fwd_a_hit, fwd_b_hit} !== 2'b11) begin
            failures++; $display("FAIL fwd_both: got %b%b expected 11", fwd_a_hit, fwd_b_hit);
        end
        src_a_addr = 3'd4; #1;
        tests++;
        if ({fwd_a_hit, fwd_b_hit} !== 2'b01) begin
            failures++; $display("FAIL fwd_a_miss: got %b%b expected 01", fwd_a_hit, fwd_b_hit);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0055, 3'd5, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec || bubble_count !== e.bub) begin
            failures++; $display("FAIL fwd_invalid_load: got %h/%h expected %h/%h", obs_vec, bubble_count, e.vec, e.bub);
        end
        src_a_addr = 3'd5; #1;
        tests++;
        if ({fwd_a_hit, fwd_b_hit, reg_write_out} !== 3'b000) begin
            failures++; $display("FAIL fwd_invalid: got %b%b rw %b expected 00 0", fwd_a_hit, fwd_b_hit, reg_write_out);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00AA, 3'd0, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++;
        if (obs_vec !== e.vec) begin
            failures++; $display("FAIL zero_load: got %h expected %h", obs_vec, e.vec);
        end
        src_a_addr = 3'd0; src_b_addr = 3'd1; #1;
        tests++;
        if ({fwd_a_hit, fwd_b_hit} !== 2'b10) begin
            failures++; $display("FAIL zero_reg_soft: got %b%b expected 10", fwd_a_hit, fwd_b_hit);
        end
        tests++;
        if ({z_fwd_a_hit, z_fwd_b_hit, z_reg_write_out} !== 3'b001) begin
            failures++; $display("FAIL zero_reg_hard: got %b%b rw %b expected 00 1", z_fwd_a_hit, z_fwd_b_hit, z_reg_write_out);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 3'd1, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (c_bubble_count !== e.bub3 || bubble_count !== e.bub || obs_vec !== e.vec) begin
                failures++; $display("FAIL sat_flush[%0d]: got %0d/%0d expected %0d/%0d", i, c_bubble_count, bubble_count, e.bub3, e.bub);
            end
        end
        tests++;
        if (c_bubble_count !== 3'd7 || bubble_count !== 16'd9) begin
            failures++; $display("FAIL sat_final: got %0d/%0d expected 7/9", c_bubble_count, bubble_count);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (c_bubble_count !== 3'd0 || bubble_count !== 16'd0) begin
            failures++; $display("FAIL sat_reset: got %0d/%0d expected 0/0", c_bubble_count, bubble_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                tests++; failures++; $display("FAIL b2b_empty[%0d]: got no entry expected one", i);
            end else begin
                e = sb.pop_front();
                tests++;
                if (obs_vec !== e.vec || bubble_count !== e.bub || c_bubble_count !== e.bub3) begin
                    failures++; $display("FAIL b2b[%0d]: got %h/%h/%0d expected %h/%h/%0d", i, obs_vec, bubble_count, c_bubble_count, e.vec, e.bub, e.bub3);
                end
            end
        end
    endtask

    initial begin
        tests = 0; failures = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        mem_to_reg_in = 1'b0; ram_read_data_in = 16'd0; alu_result_in = 16'd0;
        reg_dst_result_in = 3'd0; reg_write_in = 1'b0;
        src_a_addr = 3'd0; src_b_addr = 3'd0;
        model_reset();
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_fwd();
        test_zero_reg();
        test_saturate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
